// File: rtl/fft_seq_pkg.sv
// fft_seq_pkg: shared types and constants for the FFT RAM sequencer.
package fft_seq_pkg;
  typedef enum logic [2:0] {LOAD, START, CALC, UNLOAD, ERROR} seq_state_t;
  typedef enum logic [1:0] {OWN_BRIDGE, OWN_CORE, OWN_NONE} owner_t;
  localparam logic [19:0] WDOG_LIMIT_DEFAULT = 20'hFFFFF;
  // FFT lengths accepted by the core: powers of two from 2 to 2048
  function automatic logic valid_len(input logic [31:0] n);
    return n >= 32'd2 && n <= 32'd2048 && (n & (n - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/fft_ram_mux.sv
// fft_ram_mux: single-port RAM owner select with read data steered to the issuer of the previous read.
module fft_ram_mux
  import fft_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  owner_t                i_owner,
  input  logic                  i_br_we,
  input  logic                  i_br_re,
  input  logic [ADDR_WIDTH-1:0] i_br_addr,
  input  logic [DATA_WIDTH-1:0] i_br_wdata,
  output logic [DATA_WIDTH-1:0] o_br_rdata,
  input  logic                  i_core_we,
  input  logic                  i_core_re,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata
);
  owner_t rd_owner;
  logic br, co;
  always_comb begin
    br = i_owner == OWN_BRIDGE;
    co = i_owner == OWN_CORE;
    o_ram_we = br ? i_br_we : co && i_core_we;
    o_ram_re = br ? i_br_re : co && i_core_re;
    o_ram_addr = br ? i_br_addr : co ? i_core_addr : '0;
    o_ram_wdata = br ? i_br_wdata : co ? i_core_wdata : '0;
    o_br_rdata = rd_owner == OWN_BRIDGE ? i_ram_rdata : '0;
    o_core_rdata = rd_owner == OWN_CORE ? i_ram_rdata : '0;
  end
  // remembering who issued the read lets it return after ownership has moved on
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) rd_owner <= OWN_NONE;
    else rd_owner <= o_ram_re ? i_owner : OWN_NONE;
endmodule

// File: rtl/fft_ram_sequencer.sv
// fft_ram_sequencer: runs load/compute/unload of one FFT over the shared sample RAM,
// arbitrating it between the AXI bridge and the FFT core, with a compute watchdog.
module fft_ram_sequencer
  import fft_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int WDOG_WIDTH = 20,
  parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = WDOG_WIDTH'(WDOG_LIMIT_DEFAULT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_samples_number,
  input  logic                  i_br_write,
  input  logic                  i_br_read,
  input  logic [ADDR_WIDTH-1:0] i_br_index,
  input  logic [15:0]           i_br_wdata,
  input  logic                  i_br_data_loaded,
  input  logic                  i_br_rlast,
  output logic [DATA_WIDTH-1:0] o_br_rdata,
  output logic                  o_calc_end,
  output logic                  o_core_start,
  output logic [ADDR_WIDTH-1:0] o_core_len,
  input  logic                  i_core_we,
  input  logic                  i_core_re,
  input  logic [ADDR_WIDTH-1:0] i_core_index,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  input  logic                  i_core_done,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_error,
  output logic [2:0]            o_state
);
  seq_state_t state, state_nxt;
  owner_t owner;
  logic [WDOG_WIDTH-1:0] wdog;
  logic [ADDR_WIDTH-1:0] len;
  logic len_ok, wdog_trip;
  assign len_ok = valid_len(32'(i_samples_number));
  // wdog holds completed CALC cycles, so this cycle is the LIMIT-th one
  assign wdog_trip = wdog == WDOG_LIMIT - WDOG_WIDTH'(1);
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (i_br_data_loaded) state_nxt = len_ok ? START : ERROR;
      START:   state_nxt = CALC;
      CALC:    if (i_core_done) state_nxt = UNLOAD; else if (wdog_trip) state_nxt = ERROR;
      UNLOAD:  if (i_br_read && i_br_rlast) state_nxt = LOAD;
      ERROR:   if (i_clear) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= LOAD;
      wdog <= '0;
      len <= '0;
    end else begin
      state <= state_nxt;
      wdog <= state == CALC ? wdog + WDOG_WIDTH'(1) : '0;
      if (state == LOAD && i_br_data_loaded) len <= i_samples_number;
    end
  // reset withdraws every grant even though the state already reads LOAD
  always_comb begin
    owner = i_rst ? OWN_NONE :
            (state == LOAD || state == UNLOAD) ? OWN_BRIDGE :
            (state == START || state == CALC) ? OWN_CORE : OWN_NONE;
    o_core_start = state == START;
    o_calc_end = state == UNLOAD;
    o_busy = state == START || state == CALC;
    o_error = state == ERROR;
    o_state = state;
    o_core_len = len;
  end
  fft_ram_mux #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mux (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_owner      (owner),
    .i_br_we      (i_br_write && state == LOAD),
    .i_br_re      (i_br_read),
    .i_br_addr    (i_br_index),
    .i_br_wdata   ({(DATA_WIDTH-16)'(i_br_wdata), 16'h0}),
    .o_br_rdata   (o_br_rdata),
    .i_core_we    (i_core_we),
    .i_core_re    (i_core_re),
    .i_core_addr  (i_core_index),
    .i_core_wdata (i_core_wdata),
    .o_core_rdata (o_core_rdata),
    .o_ram_we     (o_ram_we),
    .o_ram_re     (o_ram_re),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata)
  );
endmodule
